// File: rtl/gbsha_fir_pkg.sv
// Shared definitions for the gbsha FIR test chain: default widths,
// inverse-filter FSM states and a generic signed saturation helper.
package gbsha_fir_pkg;

  localparam int DEF_BW_Y   = 4;
  localparam int DEF_BW_X   = 2;
  localparam int DEF_FRAC   = 3;
  localparam int DEF_SETTLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_RUN      = 2'd2
  } fsm_state_e;

  // Clamp v into the n-bit two's complement range (n <= 31).
  function automatic logic signed [31:0] sat_n(input logic signed [31:0] v,
                                               input int n);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (n - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (n - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/gbsha_fir_inverse_dp.sv
// Combinational datapath of the FIR inverse: one recursion step
// x_new = ((y << FRAC) - x_state) >>> 1, plus round-half-up to the output width.
module gbsha_fir_inverse_dp
  import gbsha_fir_pkg::*;
#(
  parameter int BW_y = DEF_BW_Y,
  parameter int BW_x = DEF_BW_X,
  parameter int FRAC = DEF_FRAC,
  parameter int W    = BW_y + FRAC + 1
) (
  input  logic signed [BW_y-1:0] y_i,
  input  logic signed [W-1:0]    x_state_i,
  output logic signed [W-1:0]    x_new_o,
  output logic signed [BW_x-1:0] r_o,
  output logic                   state_clip_o,
  output logic                   out_clip_o
);

  localparam int HALF = 1 << (FRAC - 1);

  logic signed [W:0]  y_sh;
  logic signed [W:0]  d;
  logic signed [W:0]  x_shift;
  logic signed [W:0]  rnd;
  logic signed [W:0]  r_wide;
  logic signed [31:0] x_ext;
  logic signed [31:0] x_sat;
  logic signed [31:0] r_ext;
  logic signed [31:0] r_sat;

  // One guard bit above W keeps the subtraction and the rounding add exact.
  always_comb begin
    y_sh         = (W+1)'(y_i) <<< FRAC;
    d            = y_sh - (W+1)'(x_state_i);
    x_shift      = d >>> 1;
    x_ext        = 32'(x_shift);
    x_sat        = sat_n(x_ext, W);
    state_clip_o = (x_sat != x_ext);
    x_new_o      = x_sat[W-1:0];

    rnd          = (W+1)'(x_new_o) + (W+1)'(HALF);
    r_wide       = rnd >>> FRAC;
    r_ext        = 32'(r_wide);
    r_sat        = sat_n(r_ext, BW_x);
    out_clip_o   = (r_sat != r_ext);
    r_o          = r_sat[BW_x-1:0];
  end

endmodule

// File: rtl/gbsha_fir_inverse.sv
// IIR inverse of y[n] = 2x[n] + x[n-1]: valid handshake, two-stage pipeline,
// settling FSM and sticky saturation flag.
//
//   state       | meaning
//   ST_IDLE     | no sample accepted since reset/clear
//   ST_SETTLING | 1..SETTLE-1 samples accepted, recursion still settling
//   ST_RUN      | SETTLE samples consumed, settled asserted
module gbsha_fir_inverse
  import gbsha_fir_pkg::*;
#(
  parameter int BW_y   = DEF_BW_Y,
  parameter int BW_x   = DEF_BW_X,
  parameter int FRAC   = DEF_FRAC,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [BW_y-1:0] y_in,
  output logic                   out_valid,
  output logic signed [BW_x-1:0] x_out,
  output logic                   settled,
  output logic                   sat
);

  localparam int W     = BW_y + FRAC + 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                   accept;
  logic signed [W-1:0]    x_new;
  logic signed [BW_x-1:0] r_new;
  logic                   state_clip;
  logic                   out_clip;

  logic signed [W-1:0]    x_state_q, x_state_d;
  logic                   v1_q, v1_d;
  logic signed [BW_x-1:0] r1_q, r1_d;
  logic                   oclip1_q, oclip1_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [BW_x-1:0] x_out_q, x_out_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  fsm_state_e             state_q, state_d;

  assign accept = in_valid & ~clear;

  gbsha_fir_inverse_dp #(
    .BW_y (BW_y),
    .BW_x (BW_x),
    .FRAC (FRAC),
    .W    (W)
  ) u_dp (
    .y_i          (y_in),
    .x_state_i    (x_state_q),
    .x_new_o      (x_new),
    .r_o          (r_new),
    .state_clip_o (state_clip),
    .out_clip_o   (out_clip)
  );

  // Rounded value and its clip flag ride along in stage 1 so the output
  // clip is only reported when it reaches x_out.
  always_comb begin
    x_state_d = x_state_q;
    r1_d      = r1_q;
    oclip1_d  = oclip1_q;
    v1_d      = accept;
    if (clear) begin
      x_state_d = '0;
    end else if (in_valid) begin
      x_state_d = x_new;
      r1_d      = r_new;
      oclip1_d  = out_clip;
    end
    out_valid_d = v1_q & ~clear;
    x_out_d     = out_valid_d ? r1_q : x_out_q;
    sat_d       = sat_q | (accept & state_clip) | (out_valid_d & oclip1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_state_q   <= '0;
      v1_q        <= 1'b0;
      r1_q        <= '0;
      oclip1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      x_state_q   <= x_state_d;
      v1_q        <= v1_d;
      r1_q        <= r1_d;
      oclip1_q    <= oclip1_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_ONE;
          state_d = (SETTLE_C == CNT_ONE) ? ST_RUN : ST_SETTLING;
        end
        ST_SETTLING: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == SETTLE_C) state_d = ST_RUN;
        end
        ST_RUN: state_d = ST_RUN;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    settled = (state_q == ST_RUN);
  end

  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign sat       = sat_q;

endmodule
